// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, instruction field positions and the fetch state type.
package cpu_pkg;

   localparam logic [3:0] OPC_ADD  = 4'h2;
   localparam logic [3:0] OPC_LD   = 4'h3;
   localparam logic [3:0] OPC_ST   = 4'h4;
   localparam logic [3:0] OPC_BEQ  = 4'h5;
   localparam logic [3:0] OPC_HALT = 4'h6;

   // Field positions within a 32-bit instruction word
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 28;
   localparam int RD_MSB  = 27;
   localparam int RD_LSB  = 24;
   localparam int RS1_MSB = 23;
   localparam int RS1_LSB = 20;
   localparam int RS2_MSB = 19;
   localparam int RS2_LSB = 16;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   function automatic logic [3:0] opc_of(input logic [31:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: redirect has priority over increment; increment wraps modulo 2^ADDR_W.
module pc_reg #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              inc_en,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= redirect_pc;
      end else if (inc_en) begin
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads combinational instruction memory and fills the
// IF/ID register under decode back-pressure, with branch redirect/flush and a sticky HALT.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter logic [3:0]        HALT_OPCODE = OPC_HALT
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_instr,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [31:0]       id_instr,
   output logic [ADDR_W-1:0] id_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted
);

   fetch_state_t      state;
   fetch_state_t      state_next;
   logic [ADDR_W-1:0] pc;
   logic              load;
   logic              is_halt;
   logic              inc_en;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect_valid),
      .redirect_pc (redirect_pc),
      .inc_en      (inc_en),
      .pc          (pc)
   );

   assign imem_addr = pc;
   assign halted    = (state == HALTED);
   assign is_halt   = (opc_of(imem_instr) == HALT_OPCODE);

   // A new word is taken only while running, when the IF/ID slot is free or draining, and no redirect
   assign load   = (state == RUN) && (!id_valid || id_ready) && !redirect_valid;
   assign inc_en = load && !is_halt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // A redirect always resumes fetching, discarding any HALT fetched down the wrong path
   always_comb begin
      state_next = state;
      if (redirect_valid) begin
         state_next = RUN;
      end else if (load && is_halt) begin
         state_next = HALTED;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_valid <= 1'b0;
         id_instr <= '0;
         id_pc    <= '0;
      end else if (redirect_valid) begin
         id_valid <= 1'b0;
      end else if (load) begin
         id_valid <= 1'b1;
         id_instr <= imem_instr;
         id_pc    <= pc;
      end else if (id_ready) begin
         id_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard of accepted IF/ID transfers plus point checks
// of halt, stall, redirect, async reset and PC wrap (second instance with ADDR_W=8).
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;

   logic [7:0]  w_imem_addr;
   logic [31:0] w_imem_instr;
   logic        w_id_valid;
   logic [31:0] w_id_instr;
   logic [7:0]  w_id_pc;
   logic        w_halted;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] prog_word(input logic [31:0] addr);
      case (addr)
         32'd0:   return 32'h22000017;
         32'd1:   return 32'h26200017;
         32'd2:   return 32'h42020003;
         32'd3:   return 32'h33000003;
         32'd4:   return 32'h60000004;
         32'd5:   return 32'h25400005;
         default: return 32'h00000000;
      endcase
   endfunction

   assign imem_instr   = prog_word(imem_addr);
   assign w_imem_instr = {24'h200000, w_imem_addr};

   fetch_stage #(
      .ADDR_W   (32),
      .RESET_PC (32'd0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted)
   );

   fetch_stage #(
      .ADDR_W   (8),
      .RESET_PC (8'd255)
   ) dut_wrap (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (w_imem_addr),
      .imem_instr     (w_imem_instr),
      .id_valid       (w_id_valid),
      .id_ready       (1'b1),
      .id_instr       (w_id_instr),
      .id_pc          (w_id_pc),
      .redirect_valid (1'b0),
      .redirect_pc    (8'd0),
      .halted         (w_halted)
   );

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expected(input int p);
      exp_q.push_back({32'(p), prog_word(32'(p))});
   endtask

   // Monitor: every transfer the decoder accepts must match the oldest expected entry
   always @(negedge clk) begin
      if (!reset && id_valid && id_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL sb_unexpected actual_pc=%0h actual_instr=%0h expected=none", id_pc, id_instr);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if (id_pc !== e[63:32] || id_instr !== e[31:0]) begin
               failures++;
               $display("[TB] FAIL sb_transfer actual_pc=%0h actual_instr=%0h expected_pc=%0h expected_instr=%0h",
                        id_pc, id_instr, e[63:32], e[31:0]);
            end
         end
      end
   end

   // Expects reset asserted and id_ready=1 on entry; runs the program up to the HALT
   task automatic apply_stimulus_straight_line(input string tag);
      check_output({tag, "_rst_valid"}, 64'(id_valid), 64'd0);
      check_output({tag, "_rst_halted"}, 64'(halted), 64'd0);
      check_output({tag, "_rst_addr"}, 64'(imem_addr), 64'd0);
      for (int p = 0; p < 5; p++) push_expected(p);
      reset = 1'b0;
      #1;
      check_output({tag, "_first_invalid"}, 64'(id_valid), 64'd0);
      for (int p = 0; p < 5; p++) begin
         step();
         check_output({tag, "_valid"}, 64'(id_valid), 64'd1);
         check_output({tag, "_pc"}, 64'(id_pc), 64'(p));
      end
      check_output({tag, "_halt_word"}, 64'(id_instr), 64'h60000004);
      check_output({tag, "_halted"}, 64'(halted), 64'd1);
      for (int k = 0; k < 2; k++) begin
         step();
         check_output({tag, "_post_halt_valid"}, 64'(id_valid), 64'd0);
         check_output({tag, "_post_halt_addr"}, 64'(imem_addr), 64'd4);
         check_output({tag, "_post_halt_halted"}, 64'(halted), 64'd1);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset          = 1'b1;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      step();
      step();

      $display("[TB] straight-line");
      apply_stimulus_straight_line("t1");

      $display("[TB] redirect out of halt");
      redirect_valid = 1'b1;
      redirect_pc    = 32'd0;
      step();
      redirect_valid = 1'b0;
      check_output("t4_halted", 64'(halted), 64'd0);
      check_output("t4_flush", 64'(id_valid), 64'd0);
      push_expected(0);
      push_expected(1);
      step();
      check_output("t4_pc", 64'(id_pc), 64'd0);
      check_output("t4_instr", 64'(id_instr), 64'h22000017);

      $display("[TB] stall");
      step();
      check_output("t2_pc1", 64'(id_pc), 64'd1);
      id_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_output("t2_hold_valid", 64'(id_valid), 64'd1);
         check_output("t2_hold_instr", 64'(id_instr), 64'h26200017);
         check_output("t2_hold_addr", 64'(imem_addr), 64'd2);
      end
      id_ready = 1'b1;
      push_expected(2);
      step();
      check_output("t2_resume_pc", 64'(id_pc), 64'd2);

      $display("[TB] redirect");
      redirect_valid = 1'b1;
      redirect_pc    = 32'd0;
      step();
      redirect_valid = 1'b0;
      check_output("t3_flush0", 64'(id_valid), 64'd0);
      push_expected(0);
      push_expected(1);
      step();
      step();
      check_output("t3_pc1", 64'(id_pc), 64'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'd5;
      step();
      redirect_valid = 1'b0;
      check_output("t3_flush", 64'(id_valid), 64'd0);
      push_expected(5);
      step();
      check_output("t3_valid", 64'(id_valid), 64'd1);
      check_output("t3_pc", 64'(id_pc), 64'd5);
      check_output("t3_instr", 64'(id_instr), 64'h25400005);

      $display("[TB] async reset mid-stall");
      @(negedge clk);
      #1;
      id_ready = 1'b0;
      step();
      check_output("t5_stalled_valid", 64'(id_valid), 64'd1);
      check_output("t5_stalled_pc", 64'(id_pc), 64'd5);
      #3;
      reset = 1'b1;
      #1;
      check_output("t5_async_valid", 64'(id_valid), 64'd0);
      check_output("t5_async_addr", 64'(imem_addr), 64'd0);
      check_output("t5_async_halted", 64'(halted), 64'd0);
      step();
      id_ready = 1'b1;
      apply_stimulus_straight_line("t5");

      $display("[TB] pc wrap");
      id_ready = 1'b0;
      reset    = 1'b1;
      step();
      check_output("t6_rst_addr", 64'(w_imem_addr), 64'd255);
      check_output("t6_rst_valid", 64'(w_id_valid), 64'd0);
      reset = 1'b0;
      step();
      check_output("t6_valid", 64'(w_id_valid), 64'd1);
      check_output("t6_pc255", 64'(w_id_pc), 64'd255);
      check_output("t6_instr255", 64'(w_id_instr), 64'h200000FF);
      step();
      check_output("t6_pc0", 64'(w_id_pc), 64'd0);
      check_output("t6_instr0", 64'(w_id_instr), 64'h20000000);
      check_output("t6_halted", 64'(w_halted), 64'd0);
      step();
      check_output("t6_pc1", 64'(w_id_pc), 64'd1);

      check_output("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
